// File: rtl/touch_i2c_pkg.sv
// Shared types and constants for the touch-panel I2C responder.
package touch_i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR,
      RX_DATA, ACK_DATA, TX_BYTE, RX_MACK, WAIT_STOP
   } state_t;

   localparam logic [3:0] REG_GESTURE = 4'd0;
   localparam logic [3:0] REG_COUNT   = 4'd1;
   localparam logic [3:0] REG_X1_HI   = 4'd2;
   localparam logic [3:0] REG_X1_LO   = 4'd3;
   localparam logic [3:0] REG_Y1_HI   = 4'd4;
   localparam logic [3:0] REG_Y1_LO   = 4'd5;
   localparam logic [3:0] REG_X2_HI   = 4'd6;
   localparam logic [3:0] REG_X2_LO   = 4'd7;
   localparam logic [3:0] REG_Y2_HI   = 4'd8;
   localparam logic [3:0] REG_Y2_LO   = 4'd9;

   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h38;

   typedef struct packed {
      logic [7:0]  gesture;
      logic [1:0]  count;
      logic [15:0] x1;
      logic [15:0] y1;
      logic [15:0] x2;
      logic [15:0] y2;
   } frame_t;

   function automatic logic [7:0] reg_byte(input frame_t f, input logic [3:0] idx);
      logic [7:0] b;
      case (idx)
         REG_GESTURE: b = f.gesture;
         REG_COUNT:   b = {6'b0, f.count};
         REG_X1_HI:   b = f.x1[15:8];
         REG_X1_LO:   b = f.x1[7:0];
         REG_Y1_HI:   b = f.y1[15:8];
         REG_Y1_LO:   b = f.y1[7:0];
         REG_X2_HI:   b = f.x2[15:8];
         REG_X2_LO:   b = f.x2[7:0];
         REG_Y2_HI:   b = f.y2[15:8];
         REG_Y2_LO:   b = f.y2[7:0];
         default:     b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/touch_i2c_responder_if.sv
// I2C pad signals plus the host-side touch frame handshake.
interface touch_i2c_responder_if;
   logic        scl_i;
   logic        sda_i;
   logic        sda_oe;
   logic        int_n;
   logic        touch_valid;
   logic        touch_ready;
   logic [15:0] touch_x1;
   logic [15:0] touch_y1;
   logic [15:0] touch_x2;
   logic [15:0] touch_y2;
   logic [1:0]  touch_count;
   logic [7:0]  touch_gesture;
   logic        busy;

   modport slave (
      input  scl_i, sda_i, touch_valid, touch_x1, touch_y1, touch_x2, touch_y2,
             touch_count, touch_gesture,
      output sda_oe, int_n, touch_ready, busy
   );

   modport master (
      output scl_i, sda_i, touch_valid, touch_x1, touch_y1, touch_x2, touch_y2,
             touch_count, touch_gesture,
      input  sda_oe, int_n, touch_ready, busy
   );
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser and FILTER_LEN-sample glitch filter for one I2C line.
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall
);
   // sh[0] is the metastability flop; sh[FILTER_LEN:1] are the filter window.
   logic [FILTER_LEN:0] sh;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh    <= '1;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sh   <= {sh[FILTER_LEN-1:0], pad};
         rise <= 1'b0;
         fall <= 1'b0;
         if ((&sh[FILTER_LEN:1]) && !level) begin
            level <= 1'b1;
            rise  <= 1'b1;
         end else if (!(|sh[FILTER_LEN:1]) && level) begin
            level <= 1'b0;
            fall  <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/touch_i2c_responder.sv
// I2C slave serving a latched touch frame: pointer write, then auto-incrementing read.
module touch_i2c_responder
   import touch_i2c_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR   = DEFAULT_DEV_ADDR,
   parameter int unsigned FILTER_LEN = 3
) (
   input logic                  clk,
   input logic                  reset_n,
   touch_i2c_responder_if.slave bus
);
   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk(clk), .reset_n(reset_n), .pad(bus.scl_i),
      .level(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk(clk), .reset_n(reset_n), .pad(bus.sda_i),
      .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   state_t      state, state_next;
   logic [7:0]  rx_sh;
   logic [6:0]  tx_sh;
   logic [3:0]  bit_cnt;
   logic [3:0]  ptr;
   frame_t      frame, shadow;
   logic        mack, sent, int_n_q, busy_q, sda_oe_q;

   logic        start_det, stop_det, byte_done, addr_hit;
   logic [7:0]  tx_cur, tx_next;

   assign start_det = sda_fall & scl;
   assign stop_det  = sda_rise & scl;
   assign byte_done = (bit_cnt == 4'd8);
   assign addr_hit  = (rx_sh[7:1] == DEV_ADDR);
   assign tx_cur    = reg_byte(shadow, ptr);
   assign tx_next   = reg_byte(shadow, ptr + 4'd1);

   assign bus.sda_oe      = sda_oe_q;
   assign bus.int_n       = int_n_q;
   assign bus.touch_ready = int_n_q;
   assign bus.busy        = busy_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (stop_det) begin
         state_next = IDLE;
      end else if (start_det) begin
         state_next = RX_ADDR;
      end else if (scl_fall) begin
         case (state)
            RX_ADDR:  if (byte_done) state_next = addr_hit ? ACK_ADDR : WAIT_STOP;
            ACK_ADDR: state_next = rx_sh[0] ? TX_BYTE : RX_PTR;
            RX_PTR:   if (byte_done) state_next = ACK_PTR;
            ACK_PTR:  state_next = RX_DATA;
            RX_DATA:  if (byte_done) state_next = ACK_DATA;
            ACK_DATA: state_next = RX_DATA;
            TX_BYTE:  if (byte_done) state_next = RX_MACK;
            RX_MACK:  state_next = mack ? WAIT_STOP : TX_BYTE;
            default:  ;
         endcase
      end
   end

   // SDA is sampled on filtered SCL rise; every sda_oe change lands the cycle after a filtered fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sh    <= '0;
         tx_sh    <= '0;
         bit_cnt  <= '0;
         ptr      <= '0;
         frame    <= '0;
         shadow   <= '0;
         mack     <= 1'b0;
         sent     <= 1'b0;
         int_n_q  <= 1'b1;
         busy_q   <= 1'b0;
         sda_oe_q <= 1'b0;
      end else begin
         if (stop_det) begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            sent     <= 1'b0;
            if (sent) int_n_q <= 1'b1;
         end else if (start_det) begin
            sda_oe_q <= 1'b0;
            bit_cnt  <= '0;
         end else if (scl_rise) begin
            case (state)
               RX_ADDR, RX_PTR, RX_DATA:
                  if (!byte_done) begin
                     rx_sh   <= {rx_sh[6:0], sda};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               TX_BYTE: if (!byte_done) bit_cnt <= bit_cnt + 4'd1;
               RX_MACK: mack <= sda;
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               RX_ADDR:
                  if (byte_done && addr_hit) begin
                     busy_q   <= 1'b1;
                     sda_oe_q <= 1'b1;
                     shadow   <= frame;
                  end
               ACK_ADDR: begin
                  bit_cnt <= '0;
                  if (rx_sh[0]) begin
                     tx_sh    <= tx_cur[6:0];
                     sda_oe_q <= ~tx_cur[7];
                  end else begin
                     sda_oe_q <= 1'b0;
                  end
               end
               RX_PTR:
                  if (byte_done) begin
                     ptr      <= rx_sh[3:0];
                     sda_oe_q <= 1'b1;
                  end
               RX_DATA: if (byte_done) sda_oe_q <= 1'b1;
               ACK_PTR: begin
                  sda_oe_q <= 1'b0;
                  bit_cnt  <= '0;
               end
               ACK_DATA: begin
                  sda_oe_q <= 1'b0;
                  bit_cnt  <= '0;
                  ptr      <= ptr + 4'd1;
               end
               TX_BYTE:
                  if (byte_done) begin
                     sda_oe_q <= 1'b0;
                     sent     <= 1'b1;
                  end else begin
                     sda_oe_q <= ~tx_sh[6];
                     tx_sh    <= {tx_sh[5:0], 1'b0};
                  end
               RX_MACK:
                  if (!mack) begin
                     ptr      <= ptr + 4'd1;
                     tx_sh    <= tx_next[6:0];
                     sda_oe_q <= ~tx_next[7];
                     bit_cnt  <= '0;
                  end
               default: ;
            endcase
         end

         // Accept after the STOP handling so a same-cycle release cannot swallow a new frame.
         if (bus.touch_valid && int_n_q) begin
            frame.gesture <= bus.touch_gesture;
            frame.count   <= bus.touch_count;
            frame.x1      <= bus.touch_x1;
            frame.y1      <= bus.touch_y1;
            frame.x2      <= bus.touch_x2;
            frame.y2      <= bus.touch_y2;
            int_n_q       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_touch_i2c_responder.sv
// Bus-level bench: open-drain I2C master model with a scoreboard of expected read bytes.
module tb_touch_i2c_responder;
   localparam int unsigned Q = 10;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   touch_i2c_responder_if bus();

   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   assign bus.scl_i = scl_m;
   assign bus.sda_i = sda_m & ~bus.sda_oe;

   touch_i2c_responder #(.DEV_ADDR(7'h38), .FILTER_LEN(3)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mem_m [16];
   logic       glitch_en = 1'b0;
   logic       mon_en = 1'b0;
   logic       oe_seen;

   always @(negedge clk) begin
      if (!mon_en)          oe_seen <= 1'b0;
      else if (bus.sda_oe)  oe_seen <= 1'b1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   function automatic void set_model(input logic [15:0] x1, input logic [15:0] y1,
                                     input logic [15:0] x2, input logic [15:0] y2,
                                     input logic [1:0] cnt, input logic [7:0] g);
      for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
      mem_m[0] = g;           mem_m[1] = {6'b0, cnt};
      mem_m[2] = x1[15:8];    mem_m[3] = x1[7:0];
      mem_m[4] = y1[15:8];    mem_m[5] = y1[7:0];
      mem_m[6] = x2[15:8];    mem_m[7] = x2[7:0];
      mem_m[8] = y2[15:8];    mem_m[9] = y2[7:0];
   endfunction

   task automatic drive_frame(input logic [15:0] x1, input logic [15:0] y1,
                              input logic [15:0] x2, input logic [15:0] y2,
                              input logic [1:0] cnt, input logic [7:0] g);
      bus.touch_x1 = x1;  bus.touch_y1 = y1;
      bus.touch_x2 = x2;  bus.touch_y2 = y2;
      bus.touch_count = cnt;  bus.touch_gesture = g;
   endtask

   task automatic load_frame(input logic [15:0] x1, input logic [15:0] y1,
                             input logic [15:0] x2, input logic [15:0] y2,
                             input logic [1:0] cnt, input logic [7:0] g);
      drive_frame(x1, y1, x2, y2, cnt, g);
      set_model(x1, y1, x2, y2, cnt, g);
      bus.touch_valid = 1'b1;
      wait_clk(1);
      bus.touch_valid = 1'b0;
      check("int_n_after_load", 32'(bus.int_n), 32'd0);
      check("ready_after_load", 32'(bus.touch_ready), 32'd0);
   endtask

   task automatic i2c_start;
      scl_m = 1'b1; sda_m = 1'b1; wait_clk(2*Q);
      sda_m = 1'b0; wait_clk(2*Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_rstart;
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2*Q);
      sda_m = 1'b0; wait_clk(2*Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(2*Q);
      sda_m = 1'b1; wait_clk(2*Q);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      if (glitch_en) begin
         scl_m = 1'b1; sda_m = b; wait_clk(1);
         scl_m = 1'b0; wait_clk(Q-1);
      end else begin
         sda_m = b; wait_clk(Q);
      end
      scl_m = 1'b1; wait_clk(Q);
      s = bus.sda_i; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(nack, s);
   endtask

   task automatic pop_check(input int idx, input logic [7:0] d);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         check($sformatf("sb_empty%0d", idx), 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("rd_byte%0d", idx), 32'(d), 32'(e));
      end
   endtask

   task automatic read_regs(input logic [7:0] ptr_byte, input int n, input bit use_model);
      logic       a;
      logic [7:0] d;
      logic [3:0] idx;
      i2c_start;
      write_byte(8'h70, a);     check("ack_addr_w", 32'(a), 32'd0);
      write_byte(ptr_byte, a);  check("ack_ptr", 32'(a), 32'd0);
      i2c_rstart;
      write_byte(8'h71, a);     check("ack_addr_r", 32'(a), 32'd0);
      check("busy_in_xfer", 32'(bus.busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         idx = ptr_byte[3:0] + 4'(i);
         if (use_model) exp_q.push_back(mem_m[idx]);
         read_byte(i == n - 1, d);
         pop_check(i, d);
      end
      i2c_stop;
      wait_clk(10);
      check("busy_after_stop", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic       a;
      logic [7:0] d;

      bus.touch_valid = 1'b0;
      drive_frame('0, '0, '0, '0, '0, '0);
      wait_clk(4);
      reset_n = 1'b1;
      wait_clk(4);
      check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
      check("rst_int_n", 32'(bus.int_n), 32'd1);
      check("rst_ready", 32'(bus.touch_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // Basic pointer write + repeated-START read of X1/Y1.
      load_frame(16'h0123, 16'h0456, 16'h0000, 16'h0000, 2'd1, 8'h10);
      exp_q.push_back(8'h01); exp_q.push_back(8'h23);
      exp_q.push_back(8'h04); exp_q.push_back(8'h56);
      read_regs(8'h02, 4, 1'b0);
      check("int_n_released", 32'(bus.int_n), 32'd1);
      check("ready_released", 32'(bus.touch_ready), 32'd1);

      // Foreign address: no ACK, SDA never driven, interrupt left pending.
      load_frame(16'hBEEF, 16'hCAFE, 16'h1357, 16'h9BDF, 2'd1, 8'h10);
      mon_en = 1'b1;
      i2c_start;
      write_byte(8'h72, a);  check("nack_wrong_addr", 32'(a), 32'd1);
      write_byte(8'h55, a);  check("nack_follow_byte", 32'(a), 32'd1);
      i2c_stop;
      wait_clk(10);
      check("oe_quiet_wrong_addr", 32'(oe_seen), 32'd0);
      mon_en = 1'b0;
      check("int_n_kept", 32'(bus.int_n), 32'd0);
      check("busy_wrong_addr", 32'(bus.busy), 32'd0);

      // Pointer wrap 0xF -> 0x0 -> 0x1.
      read_regs(8'h0F, 3, 1'b1);
      check("int_n_after_wrap_read", 32'(bus.int_n), 32'd1);

      // Snapshot: new frame offered mid-read must neither tear the read nor be accepted early.
      load_frame(16'h1111, 16'h2222, 16'hA5C3, 16'h5A3C, 2'd2, 8'h33);
      i2c_start;
      write_byte(8'h70, a);  check("snap_ack_addr_w", 32'(a), 32'd0);
      write_byte(8'hC6, a);  check("snap_ack_ptr", 32'(a), 32'd0);
      i2c_rstart;
      write_byte(8'h71, a);  check("snap_ack_addr_r", 32'(a), 32'd0);
      drive_frame(16'h7654, 16'h3210, 16'hFEDC, 16'h0BA9, 2'd3, 8'h2A);
      bus.touch_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mem_m[6 + i]);
         read_byte(i == 3, d);
         pop_check(10 + i, d);
         check("snap_ready_low", 32'(bus.touch_ready), 32'd0);
      end
      i2c_stop;
      wait_clk(20);
      check("snap_new_frame_taken", 32'(bus.int_n), 32'd0);
      bus.touch_valid = 1'b0;
      set_model(16'h7654, 16'h3210, 16'hFEDC, 16'h0BA9, 2'd3, 8'h2A);

      // One-cycle SCL glitches coinciding with every SDA change.
      glitch_en = 1'b1;
      read_regs(8'h04, 2, 1'b1);
      glitch_en = 1'b0;

      // Reset while the slave is pulling SDA low for a data bit.
      i2c_start;
      write_byte(8'h70, a);  check("rst_test_ack_w", 32'(a), 32'd0);
      write_byte(8'h00, a);  check("rst_test_ack_ptr", 32'(a), 32'd0);
      i2c_rstart;
      write_byte(8'h71, a);  check("rst_test_ack_r", 32'(a), 32'd0);
      check("tx_drive_low", 32'(bus.sda_oe), 32'd1);
      #2 reset_n = 1'b0;
      #1 check("async_release", 32'(bus.sda_oe), 32'd0);
      check("async_busy_clr", 32'(bus.busy), 32'd0);
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(2);
      check("int_n_post_reset", 32'(bus.int_n), 32'd1);
      i2c_stop;
      set_model('0, '0, '0, '0, '0, '0);
      read_regs(8'h01, 1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/touch_i2c_responder.md
Name: touch_i2c_responder

Overview:
I2C slave model of the multi-touch panel controller: the responder end of the touch I2C link. Host-side logic (bench, or a test-pattern generator on the board) loads a touch frame; the block then asserts INT_n. It serves the frame over I2C in the byte-addressed form the touch master reads: a register-pointer write, then a repeated-START read with auto-increment. It closes the loop for hardware-in-the-loop and simulation of the touch subsystem without a physical panel.

Parameters:
DEV_ADDR, 7'h38, 7-bit I2C slave address answered.
FILTER_LEN, 3, consecutive equal samples required before a synchronised SCL/SDA level is accepted.

Ports:
clk  in  1  system clock; at least 20x SCL frequency.
reset_n  in  1  asynchronous active-low reset.
scl_i  in  1  SCL pad input (asynchronous).
sda_i  in  1  SDA pad input (asynchronous).
sda_oe  out  1  1 = drive SDA low; 0 = release. Open-drain, never drives high.
int_n  out  1  touch interrupt to master, active low.
touch_valid  in  1  host offers a new frame.
touch_ready  out  1  block accepts frame; transfer when valid&ready.
touch_x1, touch_y1, touch_x2, touch_y2  in  16 each  coordinates.
touch_count  in  2  number of touch points.
touch_gesture  in  8  gesture code.
busy  out  1  high from address match to STOP.

Behaviour:
- Reset values: sda_oe=0, int_n=1, touch_ready=1, busy=0, pointer=0, frame registers=0, FSM=IDLE.
- Input conditioning: 2-FF synchroniser per line, then FILTER_LEN glitch filter. Edge/condition detect works on filtered levels. Latency from pad to detected event is 2+FILTER_LEN cycles.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are recognised in every state.
  - START: go to RX_ADDR, clear the bit counter.
  - STOP: go to IDLE, sda_oe=0.
- SDA is sampled on the filtered SCL rise. sda_oe changes only on the cycle after the filtered SCL fall.
- Register map, byte pointer 4 bits, wraps 0xF to 0x0:
  - 0x0 gesture
  - 0x1 {6'b0, count}
  - 0x2/0x3 X1 hi/lo
  - 0x4/0x5 Y1 hi/lo
  - 0x6/0x7 X2 hi/lo
  - 0x8/0x9 Y2 hi/lo
  - 0xA-0xF read 8'h00
- FSM states: IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_BYTE, RX_MACK, WAIT_STOP.
- RX_ADDR: shift 8 bits MSB first.
  - Address match: go to ACK_ADDR and set busy.
  - Mismatch: go to WAIT_STOP, no ACK.
- ACK_ADDR: drive low for one SCL high period.
  - R/W=0: go to RX_PTR.
  - R/W=1: go to TX_BYTE. Snapshot all frame registers into the tx shadow at this point so the read cannot tear.
- RX_PTR → ACK_PTR: pointer = byte[3:0]; upper nibble ignored. Then RX_DATA.
- RX_DATA/ACK_DATA: further written bytes are ACKed and discarded; pointer += 1.
- TX_BYTE: shift shadow[pointer] MSB first, sda_oe = ~bit, then release for RX_MACK.
  - Master ACK (0): pointer += 1, go to TX_BYTE.
  - Master NACK (1): go to WAIT_STOP.
- int_n:
  - Set to 0 the cycle after a valid&ready transfer.
  - Returns to 1 at the STOP ending a read transaction that sent at least 1 byte.
  - Repeated START alone does not release it.
- touch_ready = int_n. A new frame is accepted only after the previous one has been read.
- Frame registers update on valid&ready only. An update during a read does not alter the in-flight shadow.
- Reset mid-transfer: immediate release of SDA and return to IDLE. The bus must see a STOP/START before the block responds again.

Decomposition:
- Shared package touch_i2c_pkg holds:
  - state enum
  - register-index constants (REG_GESTURE=0 … REG_Y2_LO=9)
  - default DEV_ADDR
- One natural sub-module: i2c_line_filter (synchroniser plus glitch filter, instanced twice, with rise/fall outputs).

Test Plan:
- Load frame X1=16'h0123, Y1=16'h0456, X2=0, Y2=0, count=1, gesture=8'h10 → int_n=0 and touch_ready=0 one cycle later. Master writes 0x70,0x02, then Sr,0x71, reads 4 bytes (ACK,ACK,ACK,NACK), then P → reads 01 23 04 56; int_n=1 after STOP.
- Address 0x72 (wrong address) → no ACK on the 9th clock, sda_oe stays 0 until STOP, int_n unchanged.
- Pointer 0x0F, read 3 bytes → 00, 10 (gesture), 01 (count): wrap confirmed.
- Change frame inputs with valid held during a read after ACK_ADDR → bytes in flight come from the old snapshot; valid not accepted until STOP releases int_n.
- 1-cycle glitch on SCL while SDA changes (FILTER_LEN=3) → no spurious START/STOP, transfer completes correctly.
- Assert reset_n mid-TX_BYTE while driving 0 → sda_oe=0 asynchronously; after reset, a new transaction is ACKed normally.
